// File: rtl/btb_set_assoc_pkg.sv
// btb_set_assoc_pkg: BTB geometry, line layout and counter/index helpers
package btb_set_assoc_pkg;
    localparam int SETS     = 256;
    localparam int WAYS     = 2;
    localparam int CTR_BITS = 2;
    localparam int TAG_BITS = 16;
    localparam int IDX      = $clog2(SETS);
    localparam int WW       = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int LINE_W   = 1 + TAG_BITS + 30 + CTR_BITS;

    typedef logic [CTR_BITS-1:0] ctr_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [29:0]         target;
        ctr_t                ctr;
    } btb_line_t;

    localparam ctr_t CTR_MAX  = '1;
    localparam ctr_t CTR_WEAK = ctr_t'(1 << (CTR_BITS - 1));

    function automatic logic [IDX-1:0] pc_index(input logic [31:0] a);
        return a[2 +: IDX];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] a);
        return a[2 + IDX +: TAG_BITS];
    endfunction

    function automatic btb_line_t make_line(input logic [TAG_BITS-1:0] tag, input logic [31:0] tgt, input ctr_t ctr);
        return '{valid: 1'b1, tag: tag, target: tgt[31:2], ctr: ctr};
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c);
        return c == CTR_MAX ? c : c + 1'b1;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return c == '0 ? c : c - 1'b1;
    endfunction
endpackage

// File: rtl/btb_way_select.sv
// btb_way_select: collapse per-way hit vector into hit/way/counter/target
module btb_way_select #(
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2,
    parameter int WW       = 1
) (
    input  logic [WAYS-1:0]                hit_vec,
    input  logic [WAYS-1:0][CTR_BITS-1:0]  ctrs,
    input  logic [WAYS-1:0][29:0]          tgts,
    output logic                           hit,
    output logic [WW-1:0]                  way,
    output logic [CTR_BITS-1:0]            ctr,
    output logic [31:0]                    target
);
    // Scan from the top so the lowest hitting way is the one that sticks
    always_comb begin
        hit    = |hit_vec;
        way    = '0;
        ctr    = '0;
        target = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (hit_vec[w]) begin
                way    = WW'(w);
                ctr    = ctrs[w];
                target = {tgts[w], 2'b00};
            end
    end
endmodule

// File: rtl/simple_dual_port_bram.sv
// simple_dual_port_bram: one write port, one registered read port, read-first
module simple_dual_port_bram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write and read in the same edge; a colliding read returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: set-associative BTB with saturating counters and round-robin refill
module btb_set_assoc
    import btb_set_assoc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pc,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_we,
    input  logic [31:0]         id_pc,
    input  logic [31:0]         id_target,
    input  logic                id_taken,
    input  logic                id_jump,
    input  logic                id_hit,
    input  logic [WW-1:0]       id_way,
    input  logic [CTR_BITS-1:0] id_ctr,
    input  logic                id_mispredict,
    output logic                ready,
    output logic [31:0]         target,
    output logic                predict_branch_if2,
    output logic                predict_branch_if3,
    output logic                predict_hit_if3,
    output logic [WW-1:0]       predict_way_if3,
    output logic [CTR_BITS-1:0] predict_ctr_if3,
    output logic [31:0]         predict_target_if3
);
    logic [IDX-1:0]                sweep, waddr;
    logic [29:0]                   pc2;
    logic [WW-1:0]                 rr [SETS];
    logic [WAYS-1:0]               hit_vec;
    logic [WAYS-1:0][CTR_BITS-1:0] ctrs;
    logic [WAYS-1:0][29:0]         tgts;
    logic                          sel_hit, kill, upd, alloc, hit_ok, taken_raw;
    logic [WW-1:0]                 sel_way;
    ctr_t                          sel_ctr, new_ctr;
    logic [31:0]                   sel_tgt;
    btb_line_t                     wline;

    assign kill    = flush | id_mispredict;
    assign alloc   = ready & id_we & ~id_hit & (id_taken | id_jump);
    assign upd     = (ready & id_we & id_hit) | alloc;
    assign new_ctr = id_jump ? CTR_MAX : ~id_hit ? CTR_WEAK : id_taken ? sat_inc(id_ctr) : sat_dec(id_ctr);
    assign wline   = ready ? make_line(pc_tag(id_pc), id_target, new_ctr) : '0;
    assign waddr   = ready ? pc_index(id_pc) : sweep;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LINE_W-1:0] rdata;
        btb_line_t         line;
        logic              we;
        assign we = ~ready | (upd & (WAYS == 1 || id_way == WW'(w)));
        simple_dual_port_bram #(.WIDTH(LINE_W), .DEPTH(SETS)) u_bram (
            .clk(clk), .we(we), .waddr(waddr), .wdata(wline),
            .re(~stall), .raddr(pc_index(pc)), .rdata(rdata)
        );
        assign line       = btb_line_t'(rdata);
        assign hit_vec[w] = line.valid && line.tag == pc_tag({pc2, 2'b00});
        assign ctrs[w]    = line.ctr;
        assign tgts[w]    = line.target;
    end

    btb_way_select #(.WAYS(WAYS), .CTR_BITS(CTR_BITS), .WW(WW)) u_sel (
        .hit_vec(hit_vec), .ctrs(ctrs), .tgts(tgts),
        .hit(sel_hit), .way(sel_way), .ctr(sel_ctr), .target(sel_tgt)
    );

    assign hit_ok             = ready & sel_hit;
    assign taken_raw          = hit_ok & sel_ctr[CTR_BITS-1];
    assign predict_branch_if2 = taken_raw & ~kill;
    assign target             = taken_raw ? sel_tgt : {pc2 + 30'd1, 2'b00};

    // Init sweep: clear one set per cycle, ready once the last set is written
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sweep <= '0;
            ready <= 1'b0;
        end else if (!ready) begin
            sweep <= sweep + 1'b1;
            ready <= sweep == IDX'(SETS - 1);
        end

    // IF-2 pc and IF-3 prediction registers: hold on stall, clear on kill
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || kill) begin
            pc2                <= '0;
            predict_branch_if3 <= 1'b0;
            predict_hit_if3    <= 1'b0;
            predict_way_if3    <= '0;
            predict_ctr_if3    <= '0;
            predict_target_if3 <= '0;
        end else if (!stall) begin
            pc2                <= pc[31:2];
            predict_branch_if3 <= predict_branch_if2;
            predict_hit_if3    <= hit_ok;
            predict_way_if3    <= hit_ok ? sel_way : rr[pc_index({pc2, 2'b00})];
            predict_ctr_if3    <= hit_ok ? sel_ctr : '0;
            predict_target_if3 <= target;
        end

    // Round-robin victim pointer advances past each freshly allocated way
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (alloc && WAYS > 1) begin
            rr[pc_index(id_pc)] <= id_way + 1'b1;
        end
endmodule

// File: tb/tb_btb_set_assoc.sv
// tb_btb_set_assoc: random and directed checks against an array-based BTB model
module tb_btb_set_assoc;
    import btb_set_assoc_pkg::*;

    localparam int CMAX  = (1 << CTR_BITS) - 1;
    localparam int CWEAK = 1 << (CTR_BITS - 1);

    logic clk = 0, rst_n = 0;
    logic [31:0] pc = 0, id_pc = 0, id_target = 0;
    logic stall = 0, flush = 0, id_we = 0, id_taken = 0, id_jump = 0, id_hit = 0, id_mispredict = 0;
    logic [WW-1:0] id_way = 0;
    logic [CTR_BITS-1:0] id_ctr = 0;
    logic ready, predict_branch_if2, predict_branch_if3, predict_hit_if3;
    logic [31:0] target, predict_target_if3;
    logic [WW-1:0] predict_way_if3;
    logic [CTR_BITS-1:0] predict_ctr_if3;

    btb_set_assoc dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall), .flush(flush),
        .id_we(id_we), .id_pc(id_pc), .id_target(id_target), .id_taken(id_taken),
        .id_jump(id_jump), .id_hit(id_hit), .id_way(id_way), .id_ctr(id_ctr),
        .id_mispredict(id_mispredict), .ready(ready), .target(target),
        .predict_branch_if2(predict_branch_if2), .predict_branch_if3(predict_branch_if3),
        .predict_hit_if3(predict_hit_if3), .predict_way_if3(predict_way_if3),
        .predict_ctr_if3(predict_ctr_if3), .predict_target_if3(predict_target_if3)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: table contents as plain arrays, counters as integers
    bit          mv [SETS][WAYS];
    int          mt [SETS][WAYS];
    logic [31:0] mg [SETS][WAYS];
    int          mc [SETS][WAYS];
    int          mrr[SETS];
    bit          mk [SETS];
    bit          sv [WAYS];
    int          st [WAYS];
    logic [31:0] sg [WAYS];
    int          sc [WAYS];
    bit          s_known = 0, q_known = 1, m_ready = 0;
    int          m_cnt = 0;
    logic [31:0] m_pc2 = 0;
    logic        q_pb3 = 0, q_hit3 = 0;
    int          q_way3 = 0, q_ctr3 = 0;
    logic [31:0] q_tgt3 = 0;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'((a >> (2 + IDX)) % (32'd1 << TAG_BITS));
    endfunction

    typedef struct { bit hit; int way; int ctr; bit raw; logic [31:0] tgt; } pred_t;

    function automatic pred_t predict();
        pred_t p;
        p.hit = 0; p.way = 0; p.ctr = 0;
        if (m_ready)
            for (int w = 0; w < WAYS; w++)
                if (sv[w] && st[w] == tag_of(m_pc2)) begin
                    p.hit = 1; p.way = w; p.ctr = sc[w];
                    break;
                end
        p.raw = p.hit && p.ctr >= CWEAK;
        p.tgt = p.raw ? sg[p.way] : m_pc2 + 32'd4;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        pred_t p;
        int s, w;
        if (!rst_n) begin
            m_ready = 0; m_cnt = 0; m_pc2 = 0;
            q_pb3 = 0; q_hit3 = 0; q_way3 = 0; q_ctr3 = 0; q_tgt3 = 0; q_known = 1;
            for (int i = 0; i < SETS; i++) mrr[i] = 0;
        end else begin
            p = predict();
            if (flush || id_mispredict) begin
                q_pb3 = 0; q_hit3 = 0; q_way3 = 0; q_ctr3 = 0; q_tgt3 = 0; q_known = 1;
            end else if (!stall) begin
                q_pb3 = p.raw; q_hit3 = p.hit; q_ctr3 = p.ctr; q_tgt3 = p.tgt;
                q_way3 = p.hit ? p.way : mrr[idx_of(m_pc2)];
                q_known = !m_ready || s_known;
            end
            if (!stall) begin
                s = idx_of(pc);
                s_known = mk[s];
                for (int i = 0; i < WAYS; i++) begin
                    sv[i] = mv[s][i]; st[i] = mt[s][i]; sg[i] = mg[s][i]; sc[i] = mc[s][i];
                end
            end
            m_pc2 = (flush || id_mispredict) ? 32'd0 : !stall ? (pc & ~32'd3) : m_pc2;
            if (m_ready && id_we && (id_hit || id_taken || id_jump)) begin
                s = idx_of(id_pc);
                w = WAYS == 1 ? 0 : int'(id_way);
                mv[s][w] = 1; mt[s][w] = tag_of(id_pc); mg[s][w] = id_target & ~32'd3;
                mc[s][w] = id_jump ? CMAX : !id_hit ? CWEAK
                         : id_taken ? (int'(id_ctr) == CMAX ? CMAX : int'(id_ctr) + 1)
                         : (id_ctr == 0 ? 0 : int'(id_ctr) - 1);
                if (!id_hit) mrr[s] = (w + 1) % WAYS;
            end
            if (!m_ready) begin
                for (int i = 0; i < WAYS; i++) begin
                    mv[m_cnt][i] = 0; mt[m_cnt][i] = 0; mg[m_cnt][i] = 0; mc[m_cnt][i] = 0;
                end
                mk[m_cnt] = 1;
                m_cnt++;
                if (m_cnt == SETS) m_ready = 1;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin : compare
        pred_t p;
        if (rst_n) begin
            p = predict();
            check("ready", ready, m_ready);
            if (!m_ready || s_known) begin
                check("pb2", predict_branch_if2, p.raw && !flush && !id_mispredict);
                check("target", target, p.tgt);
            end
            if (q_known) begin
                check("pb3", predict_branch_if3, q_pb3);
                check("hit3", predict_hit_if3, q_hit3);
                check("way3", predict_way_if3, q_way3);
                check("ctr3", predict_ctr_if3, q_ctr3);
                check("tgt3", predict_target_if3, q_tgt3);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a, output logic pb, output logic [31:0] tg,
                          output logic h, output logic [WW-1:0] w, output logic [CTR_BITS-1:0] c);
        pc = a;
        cycle();
        pb = predict_branch_if2;
        tg = target;
        cycle();
        h = predict_hit_if3;
        w = predict_way_if3;
        c = predict_ctr_if3;
    endtask

    task automatic update(input logic [31:0] a, input logic [31:0] t, input logic tk, input logic jp,
                          input logic h, input logic [WW-1:0] w, input logic [CTR_BITS-1:0] c);
        id_we = 1; id_pc = a; id_target = t; id_taken = tk; id_jump = jp;
        id_hit = h; id_way = w; id_ctr = c;
        cycle();
        id_we = 0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ready && n < 4 * SETS) begin
            cycle();
            n++;
        end
        check(nm, n, SETS);
    endtask

    logic pb, h;
    logic [31:0] tg;
    logic [WW-1:0] w;
    logic [CTR_BITS-1:0] c;
    int exp_nt[4] = '{2, 1, 0, 0};
    int exp_pb[4] = '{1, 0, 0, 0};
    int sets_pool[5] = '{0, 3, 5, 9, 200};

    initial begin
        #3;
        check("rst_ready", ready, 0);
        check("rst_pb3", predict_branch_if3, 0);
        check("rst_hit3", predict_hit_if3, 0);
        check("rst_tgt3", predict_target_if3, 0);
        check("rst_ctr3", predict_ctr_if3, 0);
        @(posedge clk);
        #1 rst_n = 1;
        wait_ready("sweep_len");

        lookup(32'h1234_5678, pb, tg, h, w, c);
        check("empty_pb", pb, 0);
        check("empty_tgt", tg, 32'h1234_567C);

        update(32'h8000_1000, 32'h8000_2000, 1, 0, 0, 0, 0);
        lookup(32'h8000_1000, pb, tg, h, w, c);
        check("alloc_pb", pb, 1);
        check("alloc_tgt", tg, 32'h8000_2000);
        check("alloc_hit", h, 1);
        check("alloc_way", w, 0);
        check("alloc_ctr", c, 2);

        for (int i = 0; i < 4; i++) begin
            update(32'h8000_1000, 32'h8000_2000, 1, 0, 1, 0, c);
            lookup(32'h8000_1000, pb, tg, h, w, c);
            check("sat_up", c, 3);
        end
        for (int i = 0; i < 4; i++) begin
            update(32'h8000_1000, 32'h8000_2000, 0, 0, 1, 0, c);
            lookup(32'h8000_1000, pb, tg, h, w, c);
            check("sat_dn", c, exp_nt[i]);
            check("sat_dn_pb", pb, exp_pb[i]);
        end

        lookup(32'h0000_0424, pb, tg, h, w, c);
        check("conf_a_way", w, 0);
        update(32'h0000_0424, 32'h0000_A000, 1, 0, 0, w, 0);
        lookup(32'h0000_0824, pb, tg, h, w, c);
        check("conf_b_way", w, 1);
        update(32'h0000_0824, 32'h0000_B000, 1, 0, 0, w, 0);
        lookup(32'h0000_0C24, pb, tg, h, w, c);
        check("conf_c_way", w, 0);
        update(32'h0000_0C24, 32'h0000_C000, 1, 0, 0, w, 0);
        lookup(32'h0000_0424, pb, tg, h, w, c);
        check("conf_a_miss", h, 0);
        check("conf_rr", w, 1);
        lookup(32'h0000_0824, pb, tg, h, w, c);
        check("conf_b_hit", {h, 7'd0, tg}, {1'b1, 7'd0, 32'h0000_B000});
        lookup(32'h0000_0C24, pb, tg, h, w, c);
        check("conf_c_hit", {h, 7'd0, tg}, {1'b1, 7'd0, 32'h0000_C000});

        pc = 32'h0000_0014;
        id_we = 1; id_pc = 32'h0000_0014; id_target = 32'h0000_4000;
        id_taken = 1; id_jump = 0; id_hit = 0; id_way = 0; id_ctr = 0;
        cycle();
        id_we = 0;
        check("rf_old_pb", predict_branch_if2, 0);
        check("rf_old_tgt", target, 32'h0000_0018);
        cycle();
        check("rf_new_pb", predict_branch_if2, 1);
        check("rf_new_tgt", target, 32'h0000_4000);

        flush = 1;
        #1 check("flush_pb2", predict_branch_if2, 0);
        cycle();
        flush = 0;
        check("flush_hit3", predict_hit_if3, 0);
        check("flush_pb3", predict_branch_if3, 0);
        check("flush_tgt3", predict_target_if3, 0);

        rst_n = 0;
        #1 check("rst2_ready", ready, 0);
        cycle();
        rst_n = 1;
        repeat (SETS / 2) cycle();
        check("mid_ready", ready, 0);
        rst_n = 0;
        #1 check("rst3_ready", ready, 0);
        cycle();
        rst_n = 1;
        wait_ready("resweep_len");

        repeat (3000) begin
            pc = ($urandom() << 26) | ($urandom_range(0, 3) << (2 + IDX))
               | (sets_pool[$urandom_range(0, 4)] << 2);
            stall = $urandom_range(0, 9) < 2;
            flush = $urandom_range(0, 19) == 0;
            id_mispredict = $urandom_range(0, 19) == 0;
            id_we = $urandom_range(0, 1);
            id_pc = ($urandom_range(0, 3) << (2 + IDX)) | (sets_pool[$urandom_range(0, 4)] << 2);
            id_target = $urandom();
            id_taken = $urandom_range(0, 1);
            id_jump = $urandom_range(0, 5) == 0;
            id_hit = $urandom_range(0, 1);
            id_way = WW'($urandom_range(0, WAYS - 1));
            id_ctr = CTR_BITS'($urandom_range(0, CMAX));
            cycle();
        end
        stall = 0; flush = 0; id_mispredict = 0; id_we = 0;
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
